neuron_layer: RTL and testbench
===============================

Name: neuron_layer

Overview:
- Parametrised successor to the single-output neuron: M neurons share one input stream and compute y_j = act(bias_j + sum_{k=0..N-1} x[k]*w_j[k]) in parallel.
- Drives one address bus into combinational-read input and weight memories. The weight memory returns one packed word of M weights per address.
- Adds signed arithmetic, per-neuron bias, optional ReLU, output saturation and a start/busy/done handshake.

Parameters:
- N, 3: inputs per neuron, i.e. the number of accumulate steps (N >= 1).
- M, 2: neurons (channels) computed in parallel (M >= 1).
- DW, 8: width of x, of each weight and of each bias; signed two's complement.
- AW, 32: address bus width.
- ACC_W, 2*DW+$clog2(N+1)+1: accumulator width; guaranteed overflow-free.
- OW, DW+8: width of each output; results are saturated to this width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a computation; sampled only in IDLE
- relu_en  in  1  sampled with start; 1 = ReLU applied before saturation
- bias  in  M*DW  per-neuron signed bias, lane j at [j*DW +: DW]; sampled with start
- x  in  DW  input-memory read data for the address on adr (combinational)
- w  in  M*DW  weight-memory read data, lane j at [j*DW +: DW]
- adr  out  AW  shared read address for both memories
- busy  out  1  high in ACC and ACT
- done  out  1  one-cycle pulse; y is valid from this cycle on
- y  out  M*OW  signed results, lane j at [j*OW +: OW]; held until the next done

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, adr=0, cnt=0, all acc=0, y=0, busy=0, done=0, relu flag=0.
- FSM states and transitions:
  - IDLE: start=1 -> ACC. On that edge: cnt=0, adr=0, acc_j=sext(bias_j), relu flag=relu_en.
  - ACC: each edge acc_j += sext(x)*sext(w_j), full signed multiply, then cnt++ and adr=cnt+1.
    - When cnt==N-1: accumulate the last product, go to ACT, and set adr=0.
  - ACT: one edge. Apply ReLU if the flag is set (negative -> 0), saturate to OW bits signed, register y. Go to DONE.
  - DONE: done=1 for exactly this cycle; next edge -> IDLE.
- Timing and handshake:
  - Latency: done is high in the cycle after edge E0+N+1, where E0 is the edge that accepted start.
  - adr equals cnt zero-extended to AW and is stable for the entire cycle. x and w are consumed on the following edge.
  - start while busy or in DONE is ignored, not queued. Back-to-back operation requires start to be held or re-asserted in IDLE.
  - relu_en and bias changes after acceptance have no effect on the running computation.
- Arithmetic:
  - Products are 2*DW bits signed, sign-extended to ACC_W.
  - Saturation: if acc > 2^(OW-1)-1 the output is 2^(OW-1)-1; if acc < -2^(OW-1) the output is -2^(OW-1).
- Boundary conditions:
  - N=1: ACC lasts one cycle.
  - Reset mid-operation aborts immediately: no done pulse, and y returns to 0.
  - Simultaneous start and reset deassertion on the same edge: start is ignored.

Decomposition:
- Shared package (neuron_pkg):
  - state enum {IDLE, ACC, ACT, DONE}
  - function clog2
  - function sat(value, width)
- Natural sub-module: neuron_lane, one per neuron, generated M times. It holds the accumulator, multiply, ReLU and saturation, with controls clr/load_bias, acc_en and fin.
- The top level holds the FSM, cnt/adr and the generate loop.

Test Plan:
- Base case. Setup: N=3, M=2, x={1,2,3}, w0={1,1,1}, w1={-1,0,2}, bias={0,0}, relu_en=0, start pulse.
  - adr steps 0,1,2, then 0.
  - busy is high for 4 cycles.
  - done pulses once; y0=6, y1=5.
- Bias and ReLU: same setup with w1={-4,-4,-4}, bias1=3, relu_en=1. Expect y1=0 (-21 clamped); with relu_en=0, expect y1=-21.
- Saturation: OW=8, x={127,127,127}, w0={127,127,127} gives 48387, so y0=127; with w0={-128,-128,-128}, y0=-128.
- Start while busy: pulse start again at cycle 2 of ACC. Expect a single done with unchanged results, and no second run.
- Reset mid-ACC: drop rst at cnt=1. Expect y=0, adr=0 and busy=0 immediately with no done. A new start then produces correct results.
- N=1, M=1, x=-5, w=7, bias=2: done arrives 2 cycles after the start edge, y=-33.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the parallel neuron layer.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, ACC, ACT, DONE} state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Clamp a signed value into the range of a signed number of the given width.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/neuron_lane.sv
// One neuron: bias-loaded accumulator, signed MAC, optional ReLU and output saturation.
module neuron_lane
    import neuron_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 19,
    parameter int OW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_bias,
    input  logic                 acc_en,
    input  logic                 fin,
    input  logic                 relu,
    input  logic signed [DW-1:0] bias,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    output logic signed [OW-1:0] y
);

    logic signed [ACC_W-1:0] acc;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] act;

    assign prod = x * w;
    assign act  = (relu && acc[ACC_W-1]) ? '0 : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (load_bias)
                acc <= ACC_W'(bias);
            else if (acc_en)
                acc <= acc + ACC_W'(prod);
            if (fin)
                y <= OW'(sat(64'(act), OW));
        end
    end

endmodule

// File: rtl/neuron_layer.sv
// M neurons sharing one input stream; a single FSM walks the address bus over N inputs.
module neuron_layer
    import neuron_pkg::*;
#(
    parameter int N     = 3,
    parameter int M     = 2,
    parameter int DW    = 8,
    parameter int AW    = 32,
    parameter int ACC_W = 2*DW + $clog2(N+1) + 1,
    parameter int OW    = DW + 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            relu_en,
    input  logic [M*DW-1:0] bias,
    input  logic [DW-1:0]   x,
    input  logic [M*DW-1:0] w,
    output logic [AW-1:0]   adr,
    output logic            busy,
    output logic            done,
    output logic [M*OW-1:0] y
);

    localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          relu_q;
    logic          armed;
    logic          load_bias, acc_en, fin;

    // armed stays low for the first edge after reset release, so a start
    // coinciding with reset deassertion is never accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        nxt       = state;
        load_bias = 1'b0;
        acc_en    = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (start && armed) begin
                nxt       = ACC;
                load_bias = 1'b1;
            end
            ACC: begin
                acc_en = 1'b1;
                if (cnt == LAST)
                    nxt = ACT;
            end
            ACT: begin
                fin = 1'b1;
                nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            relu_q <= 1'b0;
        end else if (load_bias) begin
            cnt    <= '0;
            relu_q <= relu_en;
        end else if (acc_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign adr  = AW'(cnt);
    assign busy = (state == ACC) || (state == ACT);
    assign done = (state == DONE);

    for (genvar j = 0; j < M; j++) begin : g_lane
        neuron_lane #(
            .DW    (DW),
            .ACC_W (ACC_W),
            .OW    (OW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load_bias (load_bias),
            .acc_en    (acc_en),
            .fin       (fin),
            .relu      (relu_q),
            .bias      (bias[j*DW +: DW]),
            .x         (x),
            .w         (w[j*DW +: DW]),
            .y         (y[j*OW +: OW])
        );
    end

endmodule

// File: tb/tb_neuron_layer.sv
// Directed bench for neuron_layer: base MAC, bias/ReLU, saturation, busy restart, reset abort, N=1.
module tb_neuron_layer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=3, M=2, OW=16
    logic        start_a = 1'b0, relu_a = 1'b0;
    logic [15:0] bias_a = '0;
    logic [7:0]  x_a;
    logic [15:0] w_a;
    logic [31:0] adr_a;
    logic        busy_a, done_a;
    logic [31:0] y_a;
    logic signed [7:0] xa [4], wa0 [4], wa1 [4];

    assign x_a = xa[adr_a[1:0]];
    assign w_a = {wa1[adr_a[1:0]], wa0[adr_a[1:0]]};

    neuron_layer #(.N(3), .M(2), .DW(8), .AW(32), .OW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_a), .bias(bias_a),
        .x(x_a), .w(w_a), .adr(adr_a), .busy(busy_a), .done(done_a), .y(y_a)
    );

    // DUT C: saturation to OW=8
    logic        start_c = 1'b0;
    logic [15:0] w_c = '0;
    logic [31:0] adr_c;
    logic        busy_c, done_c;
    logic [15:0] y_c;

    neuron_layer #(.N(3), .M(2), .DW(8), .AW(32), .OW(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .relu_en(1'b0), .bias(16'h0000),
        .x(8'sd127), .w(w_c), .adr(adr_c), .busy(busy_c), .done(done_c), .y(y_c)
    );

    // DUT B: N=1, M=1
    logic        start_b = 1'b0;
    logic [31:0] adr_b;
    logic        busy_b, done_b;
    logic [15:0] y_b;

    neuron_layer #(.N(1), .M(1), .DW(8), .AW(32), .OW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .relu_en(1'b0), .bias(8'sd2),
        .x(-8'sd5), .w(8'sd7), .adr(adr_b), .busy(busy_b), .done(done_b), .y(y_b)
    );

    int checks = 0;
    int failures = 0;
    int busy_n, done_n, done_at, n;
    logic [31:0] adr_tr [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_a(input int restart_at, input bit perturb);
        logic        relu_save;
        logic [15:0] bias_save;
        relu_save = relu_a;
        bias_save = bias_a;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        if (perturb) begin
            relu_a = ~relu_a;
            bias_a = 16'h7f7f;
        end
        for (int i = 0; i < 16; i++) begin
            start_a = (i == restart_at);
            if (i < 4) adr_tr[i] = adr_a;
            if (busy_a) busy_n++;
            if (done_a) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
        start_a = 1'b0;
        relu_a  = relu_save;
        bias_a  = bias_save;
    endtask

    initial begin
        xa  = '{8'sd1, 8'sd2, 8'sd3, 8'sd0};
        wa0 = '{8'sd1, 8'sd1, 8'sd1, 8'sd0};
        wa1 = '{-8'sd1, 8'sd0, 8'sd2, 8'sd0};

        tick();
        tick();
        check("rst_y", y_a, 0);
        check("rst_adr", adr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst = 1'b1;
        tick();
        tick();

        // base case
        run_a(-1, 1'b0);
        check("base_adr0", adr_tr[0], 0);
        check("base_adr1", adr_tr[1], 1);
        check("base_adr2", adr_tr[2], 2);
        check("base_adr3", adr_tr[3], 0);
        check("base_busy_cycles", busy_n, 4);
        check("base_done_count", done_n, 1);
        check("base_done_at", done_at, 4);
        check("base_y0", $signed(y_a[15:0]), 6);
        check("base_y1", $signed(y_a[31:16]), 5);

        // bias and ReLU, with inputs disturbed after acceptance
        wa1    = '{-8'sd4, -8'sd4, -8'sd4, 8'sd0};
        bias_a = 16'h0300;
        relu_a = 1'b1;
        run_a(-1, 1'b1);
        check("relu_y0", $signed(y_a[15:0]), 6);
        check("relu_y1", $signed(y_a[31:16]), 0);
        relu_a = 1'b0;
        run_a(-1, 1'b1);
        check("norelu_y0", $signed(y_a[15:0]), 6);
        check("norelu_y1", $signed(y_a[31:16]), -21);

        // start while busy
        wa1    = '{-8'sd1, 8'sd0, 8'sd2, 8'sd0};
        bias_a = 16'h0000;
        run_a(2, 1'b0);
        check("restart_done_count", done_n, 1);
        check("restart_busy_cycles", busy_n, 4);
        check("restart_y0", $signed(y_a[15:0]), 6);
        check("restart_y1", $signed(y_a[31:16]), 5);

        // reset mid-ACC
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("midacc_adr_before", adr_a, 1);
        rst = 1'b0;
        #1;
        check("abort_y", y_a, 0);
        check("abort_adr", adr_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        tick();
        check("abort_done_held", done_a, 0);
        rst = 1'b1;
        tick();
        tick();
        run_a(-1, 1'b0);
        check("after_abort_done_count", done_n, 1);
        check("after_abort_y0", $signed(y_a[15:0]), 6);
        check("after_abort_y1", $signed(y_a[31:16]), 5);

        // saturation, OW=8
        w_c = {-8'sd128, 8'sd127};
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 20) begin
            tick();
            n++;
        end
        check("sat_done_seen", done_c, 1);
        check("sat_pos_y0", $signed(y_c[7:0]), 127);
        check("sat_neg_y1", $signed(y_c[15:8]), -128);
        tick();
        tick();
        w_c = {8'sd127, -8'sd128};
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 20) begin
            tick();
            n++;
        end
        check("sat2_done_seen", done_c, 1);
        check("sat2_neg_y0", $signed(y_c[7:0]), -128);
        check("sat2_pos_y1", $signed(y_c[15:8]), 127);

        // N=1, M=1
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("n1_busy", busy_b, 1);
        check("n1_adr", adr_b, 0);
        n = 0;
        while (!done_b && n < 20) begin
            tick();
            n++;
        end
        check("n1_latency", n, 2);
        check("n1_y", $signed(y_b), -33);
        tick();
        check("n1_done_pulse", done_b, 0);
        check("n1_y_held", $signed(y_b), -33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
